// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared types for the register-file writeback path.
//   - wb_state_e : writeback arbiter state (2 bits)
//   - wb_req_t   : one register-file write request {addr, data}
//   - REG_ZERO   : architectural zero register; writes to it are dropped
//
// The request struct is sized by WB_ADDR_W / WB_DATA_W. The arbiter's
// ADDR_SIZE / WORD_SIZE parameters default to these, so keep them in step if
// either is changed.
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;

    // IDLE : holding buffer empty, aux may be accepted
    // HELD : holding buffer full, pipeline still has priority
    // FORCE: holding buffer full, pipeline stalled for one cycle to drain it
    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_HELD  = 2'd1,
        WB_FORCE = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

    // True when a grant to this address must actually raise the write enable.
    function automatic logic wb_writes_rf(input logic [WB_ADDR_W-1:0] addr);
        return addr != REG_ZERO;
    endfunction

endpackage : mips_pkg

// File: rtl/wb_hold_buf.sv
// ---------------------------------------------------------------------------
// wb_hold_buf
//   One-entry holding register for an aux writeback that lost arbitration.
//   load has priority over clear; a load while full overwrites the entry
//   (the arbiter never does that, it only loads from IDLE).
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous reset, active-high (empties the entry)
//   load   in   capture req into the entry and mark it valid
//   clear  in   mark the entry empty (contents kept, they are don't-care)
//   req    in   request to capture
//   valid  out  entry holds a request
//   entry  out  held request
// ---------------------------------------------------------------------------
module wb_hold_buf
    import mips_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  logic    clear,
    input  wb_req_t req,
    output logic    valid,
    output wb_req_t entry
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            entry <= '0;
        end else if (load) begin
            valid <= 1'b1;
            entry <= req;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule : wb_hold_buf

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//   Owns the single register-file write port and shares it between the
//   in-order pipeline writeback and the long-latency aux unit (mul/div).
//   The pipeline has priority; a losing aux result waits in a one-entry
//   holding buffer. After STARVE_MAX consecutive pipeline writes while the
//   buffer is full, the pipeline is stalled for one cycle so the buffer drains.
//
// Handshakes
//   aux side : an aux result transfers on a cycle where aux_valid && aux_ready.
//              aux_ready depends on state only, so at most one aux result is
//              accepted per cycle and it never depends on aux_valid.
//   pipe side: there is no backpressure other than pipe_stall. When pipe_stall
//              is 1 the offered pipe_* is ignored and must be re-presented.
//
// Parameters
//   ADDR_SIZE   register address width (default 5)
//   WORD_SIZE   register data width (default 32)
//   STARVE_MAX  consecutive denied cycles before aux is force-granted (>=1)
//
// Ports
//   clk, rst                 clock / synchronous active-high reset
//   pipe_valid/addr/data     pipeline writeback request
//   pipe_stall               pipeline must hold its writeback this cycle
//   aux_valid/addr/data      aux result offered
//   aux_ready                aux result accepted when valid && ready
//   rf_we/addr/data          registered register-file write port
//   pend_valid/pend_addr     (only with WB_ARB_HAZARD_EN) an aux result is
//                            outstanding for pend_addr; used by decode to
//                            block readers of that register
//
// Configuration macro: WB_ARB_HAZARD_EN adds the pend_valid / pend_addr ports.
//
// A grant reaches rf_* on the next rising edge. Grants to register 0 still
// complete (buffer freed, handshake done) and update rf_addr/rf_data, but
// rf_we stays 0. Same-address ordering between pipe and aux is not checked
// here; the hazard unit must not issue a pipe write to a register with an aux
// result outstanding.
// ---------------------------------------------------------------------------
module wb_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_SIZE  = WB_ADDR_W,
    parameter int WORD_SIZE  = WB_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pipe_valid,
    input  logic [ADDR_SIZE-1:0] pipe_addr,
    input  logic [WORD_SIZE-1:0] pipe_data,
    output logic                 pipe_stall,
    input  logic                 aux_valid,
    output logic                 aux_ready,
    input  logic [ADDR_SIZE-1:0] aux_addr,
    input  logic [WORD_SIZE-1:0] aux_data,
    output logic                 rf_we,
    output logic [ADDR_SIZE-1:0] rf_addr,
`ifdef WB_ARB_HAZARD_EN
    output logic [WORD_SIZE-1:0] rf_data,
    output logic                 pend_valid,
    output logic [ADDR_SIZE-1:0] pend_addr
`else
    output logic [WORD_SIZE-1:0] rf_data
`endif
);

    // The counter must be able to hold STARVE_MAX itself (value while in FORCE).
    localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

    wb_state_e       state;
    wb_state_e       state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_nxt;

    wb_req_t pipe_req;
    wb_req_t aux_req;
    wb_req_t buf_entry;
    logic    buf_valid;
    logic    buf_load;
    logic    buf_clear;

    logic    grant;
    wb_req_t grant_req;

    assign pipe_req = '{addr: pipe_addr, data: pipe_data};
    assign aux_req  = '{addr: aux_addr,  data: aux_data};

    // Both are pure decodes of the state register, so neither has a
    // combinational path from any input.
    assign aux_ready  = (state == WB_IDLE);
    assign pipe_stall = (state == WB_FORCE);

    wb_hold_buf u_hold_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (buf_load),
        .clear (buf_clear),
        .req   (aux_req),
        .valid (buf_valid),
        .entry (buf_entry)
    );

    // -----------------------------------------------------------------------
    // Grant selection and next-state decode
    // -----------------------------------------------------------------------
    always_comb begin
        grant          = 1'b0;
        grant_req      = pipe_req;
        buf_load       = 1'b0;
        buf_clear      = 1'b0;
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;

        unique case (state)
            WB_IDLE: begin
                if (pipe_valid) begin
                    grant     = 1'b1;
                    grant_req = pipe_req;
                    if (aux_valid) begin
                        // Aux loses this cycle; park it and start counting.
                        buf_load       = 1'b1;
                        starve_cnt_nxt = '0;
                        state_nxt      = WB_HELD;
                    end
                end else if (aux_valid) begin
                    // Port is free: aux goes straight through, no buffering.
                    grant     = 1'b1;
                    grant_req = aux_req;
                end
            end

            WB_HELD: begin
                if (!pipe_valid) begin
                    grant          = buf_valid;
                    grant_req      = buf_entry;
                    buf_clear      = 1'b1;
                    starve_cnt_nxt = '0;
                    state_nxt      = WB_IDLE;
                end else begin
                    grant          = 1'b1;
                    grant_req      = pipe_req;
                    starve_cnt_nxt = starve_cnt + 1'b1;
                    if (starve_cnt == CNT_LAST) begin
                        state_nxt = WB_FORCE;
                    end
                end
            end

            WB_FORCE: begin
                // Pipeline is stalled this cycle; pipe_* is ignored.
                grant          = buf_valid;
                grant_req      = buf_entry;
                buf_clear      = 1'b1;
                starve_cnt_nxt = '0;
                state_nxt      = WB_IDLE;
            end

            default: begin
                buf_clear      = 1'b1;
                starve_cnt_nxt = '0;
                state_nxt      = WB_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM, starvation counter and registered write port
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WB_IDLE;
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_addr    <= '0;
            rf_data    <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            rf_we      <= grant && wb_writes_rf(grant_req.addr);
            // Without a grant the address/data hold their last values.
            if (grant) begin
                rf_addr <= grant_req.addr;
                rf_data <= grant_req.data;
            end
        end
    end

`ifdef WB_ARB_HAZARD_EN
    // A pending aux write to register 0 never lands, so it is not a hazard.
    assign pend_valid = (state != WB_IDLE) && wb_writes_rf(buf_entry.addr);
    assign pend_addr  = buf_entry.addr;
`endif

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//   Directed scenarios followed by a random phase, all checked against a
//   reference model of the arbitration rules kept in this file. Expected
//   register-file writes are also queued and matched in order against the
//   writes the design performs.
//   Build with +define+WB_ARB_HAZARD_EN to also check pend_valid/pend_addr.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int A_W   = 5;
    localparam int D_W   = 32;
    localparam int S_MAX = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           pipe_valid = 1'b0;
    logic [A_W-1:0] pipe_addr  = '0;
    logic [D_W-1:0] pipe_data  = '0;
    logic           pipe_stall;
    logic           aux_valid  = 1'b0;
    logic           aux_ready;
    logic [A_W-1:0] aux_addr   = '0;
    logic [D_W-1:0] aux_data   = '0;
    logic           rf_we;
    logic [A_W-1:0] rf_addr;
    logic [D_W-1:0] rf_data;
`ifdef WB_ARB_HAZARD_EN
    logic           pend_valid;
    logic [A_W-1:0] pend_addr;
`endif

    wb_arbiter #(
        .ADDR_SIZE  (A_W),
        .WORD_SIZE  (D_W),
        .STARVE_MAX (S_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_valid (pipe_valid),
        .pipe_addr  (pipe_addr),
        .pipe_data  (pipe_data),
        .pipe_stall (pipe_stall),
        .aux_valid  (aux_valid),
        .aux_ready  (aux_ready),
        .aux_addr   (aux_addr),
        .aux_data   (aux_data),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
`ifdef WB_ARB_HAZARD_EN
        .rf_data    (rf_data),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr)
`else
        .rf_data    (rf_data)
`endif
    );

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // An aux result that lost is "waiting"; m_waits counts pipeline writes it
    // has sat through. Once it has sat through S_MAX of them, the next cycle
    // belongs to it and the pipeline is told to stall.
    bit             m_waiting = 0;
    logic [A_W-1:0] m_w_addr  = '0;
    logic [D_W-1:0] m_w_data  = '0;
    int             m_waits   = 0;
    logic [A_W-1:0] m_rf_addr = '0;
    logic [D_W-1:0] m_rf_data = '0;

    logic [A_W+D_W-1:0] exp_q[$];

    // last observed values, for directed checks
    logic obs_stall;
    logic obs_ready;

    task automatic model_reset();
        m_waiting = 0;
        m_waits   = 0;
        m_rf_addr = '0;
        m_rf_data = '0;
        exp_q.delete();
    endtask

    // ---------------- driver ----------------
    // One clock cycle: drive inputs at the falling edge, check the state-only
    // outputs, let the rising edge happen, then check the write port.
    task automatic step(input logic pv, input logic [A_W-1:0] pa, input logic [D_W-1:0] pd,
                        input logic av, input logic [A_W-1:0] aa, input logic [D_W-1:0] ad);
        bit             e_stall;
        bit             w_valid;
        logic [A_W-1:0] w_addr;
        logic [D_W-1:0] w_data;
        logic [A_W+D_W-1:0] got;

        @(negedge clk);
        pipe_valid = pv; pipe_addr = pa; pipe_data = pd;
        aux_valid  = av; aux_addr  = aa; aux_data  = ad;
        #1;
        e_stall = m_waiting && (m_waits == S_MAX);
        obs_stall = pipe_stall;
        obs_ready = aux_ready;
        chk("pipe_stall", 64'(pipe_stall), 64'(e_stall));
        chk("aux_ready",  64'(aux_ready),  64'(!m_waiting));
`ifdef WB_ARB_HAZARD_EN
        chk("pend_valid", 64'(pend_valid), 64'(m_waiting && (m_w_addr != 0)));
        if (m_waiting) chk("pend_addr", 64'(pend_addr), 64'(m_w_addr));
`endif

        w_valid = 1'b0; w_addr = '0; w_data = '0;
        if (m_waiting && (e_stall || !pv)) begin
            w_valid = 1'b1; w_addr = m_w_addr; w_data = m_w_data;
            m_waiting = 0; m_waits = 0;
        end else if (m_waiting) begin
            w_valid = 1'b1; w_addr = pa; w_data = pd;
            m_waits++;
        end else if (pv) begin
            w_valid = 1'b1; w_addr = pa; w_data = pd;
            if (av) begin
                m_waiting = 1; m_w_addr = aa; m_w_data = ad; m_waits = 0;
            end
        end else if (av) begin
            w_valid = 1'b1; w_addr = aa; w_data = ad;
        end
        if (w_valid) begin
            m_rf_addr = w_addr;
            m_rf_data = w_data;
            if (w_addr != 0) exp_q.push_back({w_addr, w_data});
        end

        @(posedge clk);
        #1;
        chk("rf_we",   64'(rf_we),   64'(w_valid && (w_addr != 0)));
        chk("rf_addr", 64'(rf_addr), 64'(m_rf_addr));
        chk("rf_data", 64'(rf_data), 64'(m_rf_data));
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_write", 64'(1), 64'(0));
            end else begin
                got = exp_q.pop_front();
                chk("sb_write", 64'({rf_addr, rf_data}), 64'(got));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0);
    endtask

    // Reset with every request line asserted, as a stressed pipeline would.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        pipe_valid = 1'b1; pipe_addr = 5'd12; pipe_data = 32'hAAAA_0000;
        aux_valid  = 1'b1; aux_addr  = 5'd13; aux_data  = 32'hBBBB_0000;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("rst_rf_we",      64'(rf_we),      64'(0));
            chk("rst_pipe_stall", 64'(pipe_stall), 64'(0));
            chk("rst_rf_addr",    64'(rf_addr),    64'(0));
            chk("rst_rf_data",    64'(rf_data),    64'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        pipe_valid = 1'b0;
        aux_valid  = 1'b0;
        #1;
        chk("rst_aux_ready",  64'(aux_ready),  64'(1));
        chk("rst_pipe_stall2", 64'(pipe_stall), 64'(0));
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int stall_at;
        int stall_cnt;

        // 1. reset
        do_reset(2);

        // 2. aux only, goes straight through
        step(0, '0, '0, 1, 5'd7, 32'hDEAD_BEEF);
        chk("t2_we",    64'(rf_we),   64'(1));
        chk("t2_addr",  64'(rf_addr), 64'(7));
        chk("t2_data",  64'(rf_data), 64'hDEAD_BEEF);
        chk("t2_ready", 64'(aux_ready), 64'(1));
        idle(1);
        chk("t2_hold_addr", 64'(rf_addr), 64'(7));

        // 3. collision, pipe first then aux
        step(1, 5'd3, 32'h11, 1, 5'd9, 32'h22);
        chk("t3_w1_addr", 64'(rf_addr), 64'(3));
        chk("t3_w1_data", 64'(rf_data), 64'h11);
        step(0, '0, '0, 0, '0, '0);
        chk("t3_ready_low", 64'(obs_ready), 64'(0));
        chk("t3_w2_addr",   64'(rf_addr),   64'(9));
        chk("t3_w2_data",   64'(rf_data),   64'h22);
        idle(1);
        chk("t3_ready_back", 64'(obs_ready), 64'(1));

        // 4. starvation: aux held, pipeline never lets up
        step(1, 5'd1, 32'h100, 1, 5'd20, 32'hA0A0);
        stall_at = 0; stall_cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            step(1, 5'(i + 1), 32'h100 + i, 0, '0, '0);
            if (obs_stall) begin
                stall_cnt++;
                stall_at = i;
                chk("t4_aux_drained", 64'(rf_addr), 64'(20));
            end
        end
        chk("t4_stall_cycle", 64'(stall_at),  64'(5));
        chk("t4_stall_count", 64'(stall_cnt), 64'(1));
        chk("t4_pipe_resumed", 64'(rf_addr), 64'(7));

        // 5. register 0
        step(1, 5'd0, 32'h55, 0, '0, '0);
        chk("t5_pipe_r0_we",   64'(rf_we),   64'(0));
        chk("t5_pipe_r0_data", 64'(rf_data), 64'h55);
        step(1, 5'd4, 32'h44, 1, 5'd0, 32'h66);
        step(0, '0, '0, 0, '0, '0);
        chk("t5_aux_r0_we", 64'(rf_we), 64'(0));
        idle(1);
        chk("t5_ready_back", 64'(obs_ready), 64'(1));

        // 6. reset while HELD with two pipeline writes counted
        step(1, 5'd3, 32'h33, 1, 5'd9, 32'h99);
        step(1, 5'd5, 32'h55, 0, '0, '0);
        step(1, 5'd6, 32'h66, 0, '0, '0);
`ifdef WB_ARB_HAZARD_EN
        #1;
        chk("t6_pend_valid", 64'(pend_valid), 64'(1));
        chk("t6_pend_addr",  64'(pend_addr),  64'(9));
`endif
        do_reset(1);
        idle(3);
        // counter restarted: a new hold must again survive 4 pipeline writes
        step(1, 5'd10, 32'h1010, 1, 5'd11, 32'h1111);
        for (int i = 0; i < 5; i++) step(1, 5'(14 + i), $urandom, 0, '0, '0);
        idle(2);

        // random phase
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom);
        end
        idle(3);
        chk("sb_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_wb_arbiter
